ready_pattern_gen: RTL and testbench

- Multi-channel, parametrised ready-backpressure generator for simulation test harnesses. It succeeds the single-channel "ready drops after N cycles" block.
- Each channel drives `ready = internal ready state AND valid` combinationally. The internal ready state follows a selectable pattern: always-on, one-shot drop, periodic high/low, or always-off.
- Each channel counts accepted transfers.
- Sits between a stimulus source and a DUT to exercise combinational valid→ready paths and stall handling.

---
 rtl/ready_pattern_pkg.sv | 21 ++
 rtl/ready_pattern_ch.sv | 117 +++++++++++
 rtl/ready_pattern_gen.sv | 77 +++++++
 tb/tb_ready_pattern_gen.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ready_pattern_pkg.sv
// Shared types for the ready-backpressure pattern generator.
package ready_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_ON       = 2'd0,
    MODE_ONE_SHOT = 2'd1,
    MODE_PERIODIC = 2'd2,
    MODE_OFF      = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_HI   = 2'd0,
    ST_LO   = 2'd1,
    ST_DONE = 2'd2
  } ch_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ready_pattern_ch.sv
// One valid/ready channel: pattern FSM, phase counter, ready gating and a
// saturating accepted-transfer counter.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_HI   | ready state high (ON, ONE_SHOT before drop, PERIODIC high phase)
// ST_LO   | PERIODIC low phase
// ST_DONE | ONE_SHOT has dropped; sticky until restart or reset
module ready_pattern_ch
  import ready_pattern_pkg::*;
#(
  parameter int HI_CYCLES = 3,
  parameter int LO_CYCLES = 2,
  parameter int XFER_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              restart,
  input  logic              rdy_init,
  input  logic              en,
  input  mode_e             mode_q,
  input  logic              drop_hit,
  input  logic              valid,
  output logic              ready,
  output logic [XFER_W-1:0] xfer_cnt
);

  localparam int PH_W = $clog2(max_int(HI_CYCLES, LO_CYCLES) + 1);
  localparam logic [PH_W-1:0] HI_LAST = PH_W'(HI_CYCLES - 1);
  localparam logic [PH_W-1:0] LO_LAST = PH_W'(LO_CYCLES - 1);

  ch_state_e          state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic               rdy_q, rdy_d;
  logic [XFER_W-1:0]  xfer_q, xfer_d;

  // Ready is combinational from valid so the downstream sees zero latency.
  assign ready    = rdy_q & valid;
  assign xfer_cnt = xfer_q;

  // Register channel state; reset leaves the channel fully ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_HI;
      phase_q <= '0;
      rdy_q   <= 1'b1;
      xfer_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rdy_q   <= rdy_d;
      xfer_q  <= xfer_d;
    end
  end

  // Pattern next-state: restart wins, otherwise advance only while enabled.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rdy_d   = rdy_q;
    if (restart) begin
      state_d = ST_HI;
      phase_d = '0;
      rdy_d   = rdy_init;
    end else if (en) begin
      case (mode_q)
        MODE_ON: begin
          rdy_d   = 1'b1;
          state_d = ST_HI;
        end
        MODE_OFF: begin
          rdy_d = 1'b0;
        end
        MODE_ONE_SHOT: begin
          if (state_q == ST_HI && drop_hit) begin
            state_d = ST_DONE;
            rdy_d   = 1'b0;
          end
        end
        MODE_PERIODIC: begin
          case (state_q)
            ST_LO: begin
              if (phase_q == LO_LAST) begin
                state_d = ST_HI;
                phase_d = '0;
                rdy_d   = 1'b1;
              end else begin
                phase_d = phase_q + 1'b1;
              end
            end
            // ST_DONE cannot coexist with PERIODIC (mode change restarts),
            // so it is folded into the high phase.
            default: begin
              if (phase_q == HI_LAST) begin
                state_d = ST_LO;
                phase_d = '0;
                rdy_d   = 1'b0;
              end else begin
                phase_d = phase_q + 1'b1;
              end
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  // Count accepted transfers regardless of en/restart, saturating at all-ones.
  always_comb begin
    xfer_d = xfer_q;
    if (valid && rdy_q && (xfer_q != '1)) begin
      xfer_d = xfer_q + 1'b1;
    end
  end

endmodule

// File: rtl/ready_pattern_gen.sv
// Multi-channel ready-backpressure generator: global cycle counter, latched
// mode with restart-on-change, and NUM_CH in-phase pattern channels.
module ready_pattern_gen
  import ready_pattern_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 16,
  parameter int DROP_CYCLE = 2,
  parameter int HI_CYCLES  = 3,
  parameter int LO_CYCLES  = 2,
  parameter int XFER_W     = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [1:0]               mode,
  input  logic                     en,
  input  logic [NUM_CH-1:0]        valid,
  output logic [NUM_CH-1:0]        ready,
  output logic [NUM_CH*XFER_W-1:0] xfer_cnt,
  output logic [CNT_W-1:0]         cycles
);

  mode_e            mode_in;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             restart;
  logic             rdy_init;
  logic             drop_hit;

  assign mode_in  = mode_e'(mode);
  assign restart  = (mode_in != mode_q);
  assign rdy_init = (mode_in != MODE_OFF);
  assign drop_hit = (cycles_q == CNT_W'(DROP_CYCLE));
  assign cycles   = cycles_q;

  // Register the latched mode and the global cycle counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q   <= MODE_ON;
      cycles_q <= '0;
    end else begin
      mode_q   <= mode_d;
      cycles_q <= cycles_d;
    end
  end

  // A mode change restarts the pattern and overrides en that edge.
  always_comb begin
    mode_d   = mode_in;
    cycles_d = cycles_q;
    if (restart) begin
      cycles_d = '0;
    end else if (en) begin
      cycles_d = cycles_q + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ready_pattern_ch #(
      .HI_CYCLES (HI_CYCLES),
      .LO_CYCLES (LO_CYCLES),
      .XFER_W    (XFER_W)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .restart  (restart),
      .rdy_init (rdy_init),
      .en       (en),
      .mode_q   (mode_q),
      .drop_hit (drop_hit),
      .valid    (valid[i]),
      .ready    (ready[i]),
      .xfer_cnt (xfer_cnt[i*XFER_W +: XFER_W])
    );
  end

endmodule

// File: tb/tb_ready_pattern_gen.sv
// Directed bench for ready_pattern_gen: default instance plus a 3-bit
// transfer-counter instance for saturation.
module tb_ready_pattern_gen;

  logic         clock;
  logic         reset;
  logic [1:0]   mode;
  logic         en;
  logic [3:0]   valid;
  logic [3:0]   ready;
  logic [127:0] xfer_cnt;
  logic [15:0]  cycles;

  logic         reset_s;
  logic [1:0]   mode_s;
  logic         en_s;
  logic [3:0]   valid_s;
  logic [3:0]   ready_s;
  logic [11:0]  xfer_s;
  logic [15:0]  cycles_s;

  int n_checks = 0;
  int n_err    = 0;

  ready_pattern_gen u_dut (
    .clock    (clock),
    .reset    (reset),
    .mode     (mode),
    .en       (en),
    .valid    (valid),
    .ready    (ready),
    .xfer_cnt (xfer_cnt),
    .cycles   (cycles)
  );

  ready_pattern_gen #(.XFER_W(3)) u_sat (
    .clock    (clock),
    .reset    (reset_s),
    .mode     (mode_s),
    .en       (en_s),
    .valid    (valid_s),
    .ready    (ready_s),
    .xfer_cnt (xfer_s),
    .cycles   (cycles_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] xch(input int i);
    return xfer_cnt[i*32 +: 32];
  endfunction

  initial begin
    reset = 1; mode = 2'd0; en = 1; valid = 4'h0;
    reset_s = 1; mode_s = 2'd0; en_s = 1; valid_s = 4'h0;
    tick();
    tick();
    check("rst_cycles", 128'(cycles), 0);
    check("rst_xfer", xfer_cnt, 0);
    valid = 4'hA; #1;
    check("rst_ready_eq_valid", 128'(ready), 4'hA);

    // Release reset in ON with no traffic.
    reset = 0; valid = 4'h0;
    tick();
    check("edge0_cycles", 128'(cycles), 1);

    // ONE_SHOT: restart edge, then exactly 3 ready cycles.
    mode = 2'd1;
    tick();
    check("os_restart_cycles", 128'(cycles), 0);
    valid = 4'hF; #1;
    for (int k = 0; k < 3; k++) begin
      check("os_ready_hi", 128'(ready), 4'hF);
      tick();
    end
    check("os_ready_drop", 128'(ready), 4'h0);
    check("os_cycles3", 128'(cycles), 3);
    repeat (17) tick();
    check("os_ready_sticky", 128'(ready), 4'h0);
    check("os_cycles20", 128'(cycles), 20);
    check("os_xfer_ch0", 128'(xch(0)), 3);
    check("os_xfer_ch3", 128'(xch(3)), 3);

    // DONE -> ON: ready back immediately, cycles restarted.
    mode = 2'd0;
    tick();
    check("on_restart_cycles", 128'(cycles), 0);
    check("on_restart_ready", 128'(ready), 4'hF);
    check("on_restart_xfer", 128'(xch(0)), 3);

    // ON -> ONE_SHOT again: restart edge counts (rdy was 1), then 3 more.
    mode = 2'd1;
    tick();
    for (int k = 0; k < 3; k++) begin
      check("os2_ready_hi", 128'(ready), 4'hF);
      tick();
    end
    check("os2_ready_drop", 128'(ready), 4'h0);
    check("os2_xfer_ch1", 128'(xch(1)), 7);

    // ONE_SHOT with en low for 5 edges after the first edge.
    mode = 2'd0; valid = 4'h0;
    tick();
    mode = 2'd1;
    tick();
    valid = 4'hF;
    tick();
    check("frz_cycles_first", 128'(cycles), 1);
    en = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("frz_ready", 128'(ready), 4'hF);
    end
    check("frz_cycles_held", 128'(cycles), 1);
    en = 1;
    tick();
    check("frz_cycles2", 128'(cycles), 2);
    check("frz_ready_late", 128'(ready), 4'hF);
    tick();
    check("frz_ready_drop", 128'(ready), 4'h0);
    check("frz_xfer_ch2", 128'(xch(2)), 15);

    // PERIODIC: 1,1,1,0,0 repeating.
    valid = 4'h0; mode = 2'd2;
    tick();
    valid = 4'hF; #1;
    for (int k = 0; k < 10; k++) begin
      check("per_ready", 128'(ready), ((k % 5) < 3) ? 4'hF : 4'h0);
      tick();
    end
    check("per_xfer_ch0", 128'(xch(0)), 21);
    check("per_xfer_ch3", 128'(xch(3)), 21);
    tick(); tick(); tick();
    check("per_in_lo", 128'(ready), 4'h0);

    // Reset for one edge during LO.
    reset = 1;
    tick();
    reset = 0;
    check("rst_mid_xfer", xfer_cnt, 0);
    check("rst_mid_cycles", 128'(cycles), 0);
    check("rst_mid_ready", 128'(ready), 4'hF);

    // ON with valid toggled mid-cycle: ready follows with no latency.
    mode = 2'd0; valid = 4'b0101; #1;
    check("on_ready_0101", 128'(ready), 4'b0101);
    for (int k = 0; k < 8; k++) begin
      tick();
      valid = 4'b0000; #1;
      if (k == 0) check("on_ready_toggle_lo", 128'(ready), 4'b0000);
      valid = 4'b0101; #1;
      if (k == 0) check("on_ready_toggle_hi", 128'(ready), 4'b0101);
    end
    check("on_xfer_ch0", 128'(xch(0)), 8);
    check("on_xfer_ch1", 128'(xch(1)), 0);
    check("on_xfer_ch2", 128'(xch(2)), 8);
    check("on_xfer_ch3", 128'(xch(3)), 0);

    // Saturation with a 3-bit transfer counter.
    reset_s = 0; valid_s = 4'b0001;
    repeat (10) tick();
    check("sat_xfer", 128'(xfer_s), 12'h007);
    repeat (3) tick();
    check("sat_xfer_held", 128'(xfer_s), 12'h007);

    // OFF forces ready low despite valid.
    mode_s = 2'd3;
    tick();
    check("off_ready_sat", 128'(ready_s), 4'h0);
    mode = 2'd3;
    tick();
    check("off_ready", 128'(ready), 4'h0);
    check("off_cycles", 128'(cycles), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
